// File: rtl/restoring_divider_if.sv
// Request/result bundle for the restoring divider.
// start is only honoured while busy is low; done pulses for one cycle when Q/R/div_by_zero update.
interface restoring_divider_if #(
   parameter int N = 8
);
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         busy;
   logic         done;
   logic [N-1:0] Q;
   logic [N-1:0] R;
   logic         div_by_zero;

   modport master (
      output start, A, B,
      input  busy, done, Q, R, div_by_zero
   );

   modport slave (
      input  start, A, B,
      output busy, done, Q, R, div_by_zero
   );
endinterface

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, N clocks per division.
// Divide-by-zero short-circuits to DONE with Q = all ones and R = dividend.
module restoring_divider #(
   parameter int N = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   restoring_divider_if.slave   bus,
   output logic [1:0]           fsm_state
);
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [N-1:0]  dvd;
   logic [N-1:0]  dsr;
   logic [N:0]    rem;
   logic [CW-1:0] cnt;

   logic [N:0]    rem_shift;
   logic [N:0]    trial;
   logic [N:0]    rem_next;
   logic [N-1:0]  dvd_next;

   assign fsm_state = state;

   // The remainder before a shift is always below B, so the N+1-bit trial's MSB is a valid sign.
   always_comb begin
      rem_shift = {rem[N-1:0], dvd[N-1]};
      trial     = rem_shift - {1'b0, dsr};
      rem_next  = rem_shift;
      dvd_next  = {dvd[N-2:0], 1'b0};
      if (!trial[N]) begin
         rem_next = trial;
         dvd_next = {dvd[N-2:0], 1'b1};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         dvd             <= '0;
         dsr             <= '0;
         rem             <= '0;
         cnt             <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.Q           <= '0;
         bus.R           <= '0;
         bus.div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  dvd      <= bus.A;
                  dsr      <= bus.B;
                  rem      <= '0;
                  cnt      <= CW'(N);
                  bus.busy <= 1'b1;
                  if (bus.B == '0) begin
                     bus.Q           <= '1;
                     bus.R           <= bus.A;
                     bus.div_by_zero <= 1'b1;
                     bus.done        <= 1'b1;
                     state           <= DONE;
                  end else begin
                     bus.div_by_zero <= 1'b0;
                     state           <= CALC;
                  end
               end
            end
            CALC: begin
               dvd <= dvd_next;
               rem <= rem_next;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  bus.Q    <= dvd_next;
                  bus.R    <= rem_next[N-1:0];
                  bus.done <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboarded bench for restoring_divider: directed corner cases, reset abort, held start
// and a randomized run; every done pulse is matched against a queued expected result.
module tb_restoring_divider;
   localparam int N = 8;

   logic       clock;
   logic       reset_n;
   logic [1:0] fsm_state;

   restoring_divider_if #(.N(N)) bus ();

   restoring_divider #(.N(N)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .bus       (bus.slave),
      .fsm_state (fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- scoreboard ----------------
   logic [2*N:0]   exp_q[$];   // {Q, R, div_by_zero}
   logic [2*N-1:0] op_q[$];    // {A, B}
   int checks   = 0;
   int errors   = 0;
   int accepted = 0;
   int done_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [2*N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
      if (b == '0) return {{N{1'b1}}, a, 1'b1};
      return {a / b, a % b, 1'b0};
   endfunction

   always @(negedge clock) begin
      if (bus.done) begin
         logic [2*N:0]   e;
         logic [2*N-1:0] op;
         int qa, qb, qq, qr;
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e  = exp_q.pop_front();
            op = op_q.pop_front();
            check("quotient",    32'(bus.Q), 32'(e[2*N:N+1]));
            check("remainder",   32'(bus.R), 32'(e[N:1]));
            check("div_by_zero", 32'(bus.div_by_zero), 32'(e[0]));
            qa = int'(op[2*N-1:N]);
            qb = int'(op[N-1:0]);
            qq = int'(bus.Q);
            qr = int'(bus.R);
            if (qb != 0) begin
               check("identity",   32'(qq * qb + qr), 32'(qa));
               check("rem_lt_div", 32'(qr < qb), 32'd1);
            end
         end
      end
   end

   // ---------------- driver ----------------
   // Called right after a negedge with the DUT idle; returns at the negedge where busy has dropped.
   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b);
      int lat;
      int bcnt;
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      exp_q.push_back(model(a, b));
      op_q.push_back({a, b});
      accepted++;
      @(posedge clock);
      lat  = -1;
      bcnt = 0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clock);
         if (j == 0) begin
            bus.start = 1'b0;
            bus.A     = N'($urandom_range(255));
            bus.B     = N'($urandom_range(255));
         end
         if (bus.busy) bcnt++;
         if (bus.done) lat = j;
         if (!bus.busy) break;
      end
      check("done_latency", 32'(lat),  (b == '0) ? 32'd0 : 32'd8);
      check("busy_cycles",  32'(bcnt), (b == '0) ? 32'd1 : 32'd9);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int lat;
      int dc;
      reset_n   = 1'b0;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      repeat (3) @(negedge clock);
      check("rst_busy",  32'(bus.busy), 32'd0);
      check("rst_done",  32'(bus.done), 32'd0);
      check("rst_q",     32'(bus.Q), 32'd0);
      check("rst_r",     32'(bus.R), 32'd0);
      check("rst_dbz",   32'(bus.div_by_zero), 32'd0);
      check("rst_state", 32'(fsm_state), 32'd0);

      // first start lands on the first edge after release
      reset_n = 1'b1;
      do_op(8'd100, 8'd7);
      repeat (3) @(negedge clock);
      check("hold_q", 32'(bus.Q), 32'd14);
      check("hold_r", 32'(bus.R), 32'd2);

      // reset in the 4th CALC cycle aborts without a done pulse
      dc = done_cnt;
      bus.start = 1'b1;
      bus.A     = 8'd100;
      bus.B     = 8'd7;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
      repeat (3) @(negedge clock);
      check("pre_abort_busy", 32'(bus.busy), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("abort_busy",  32'(bus.busy), 32'd0);
      check("abort_state", 32'(fsm_state), 32'd0);
      check("abort_q",     32'(bus.Q), 32'd0);
      check("abort_r",     32'(bus.R), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (12) @(negedge clock);
      check("abort_no_done", 32'(done_cnt - dc), 32'd0);
      do_op(8'd100, 8'd7);

      // boundary operands and divide-by-zero
      do_op(8'd255, 8'd1);
      do_op(8'd5,   8'd9);
      do_op(8'd0,   8'd3);
      do_op(8'd200, 8'd0);
      do_op(8'd9,   8'd3);
      do_op(8'd0,   8'd0);
      do_op(8'd255, 8'd255);

      // start held high; operands change mid-CALC
      bus.start = 1'b1;
      bus.A     = 8'd50;
      bus.B     = 8'd5;
      exp_q.push_back(model(8'd50, 8'd5));
      op_q.push_back({8'd50, 8'd5});
      exp_q.push_back(model(8'd1, 8'd1));
      op_q.push_back({8'd1, 8'd1});
      accepted += 2;
      @(posedge clock);
      @(negedge clock);
      bus.A = 8'd1;
      bus.B = 8'd1;
      lat = -1;
      for (int j = 1; j < 40; j++) begin
         @(negedge clock);
         if (bus.done) begin
            lat = j;
            break;
         end
      end
      check("held_latency", 32'(lat), 32'd8);
      @(negedge clock);
      check("held_idle_gap", 32'(bus.busy), 32'd0);
      @(negedge clock);
      check("held_reaccept", 32'(bus.busy), 32'd1);
      bus.start = 1'b0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clock);
         if (!bus.busy) break;
      end
      check("held_finished", 32'(bus.busy), 32'd0);

      // randomized operations
      for (int i = 0; i < 1000; i++) begin
         do_op(N'($urandom_range(255)), N'($urandom_range(255, 1)));
      end

      repeat (3) @(negedge clock);
      check("done_per_start", 32'(done_cnt), 32'(accepted));
      check("queue_empty",    32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
